// File: rtl/decoder_scan.sv
// N-to-2^N one-hot select generator with registered outputs, blanking and
// an auto-scan mode that walks the active line at one step every DIV clocks.
module decoder_scan #(
    parameter int N   = 2,
    parameter int DIV = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                mode,
    input  logic                load,
    input  logic                dir,
    input  logic [N-1:0]        a,
    output logic [(1<<N)-1:0]   y,
    output logic [N-1:0]        idx,
    output logic                wrap,
    output logic [1:0]          dbg_state
);

    localparam int W  = 1 << N;
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(DIV - 1);
    localparam logic [N-1:0]  IDX_MAX    = {N{1'b1}};

    // Encoding is visible on dbg_state: 0 = OFF, 1 = DECODE, 2 = SCAN.
    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_DECODE = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_d;
    logic [N-1:0]    idx_d;
    logic [N-1:0]    idx_step;
    logic            step_wraps;
    logic            wrap_d;
    logic [W-1:0]    y_d;

    always_comb begin
        state_d    = en ? (mode ? ST_SCAN : ST_DECODE) : ST_OFF;
        idx_step   = dir ? (idx - N'(1)) : (idx + N'(1));
        step_wraps = dir ? (idx == '0) : (idx == IDX_MAX);
        idx_d      = idx;
        count_d    = count;
        wrap_d     = 1'b0;

        // Actions follow the state being entered, so a mode or enable change
        // takes effect on the same edge that samples it and never steps.
        case (state_d)
            ST_OFF: begin
                count_d = '0;
            end
            ST_DECODE: begin
                idx_d   = a;
                count_d = '0;
            end
            ST_SCAN: begin
                if (load) begin
                    idx_d   = a;
                    count_d = '0;
                end else if (state != ST_SCAN) begin
                    count_d = '0;
                end else if (count == COUNT_LAST) begin
                    idx_d   = idx_step;
                    count_d = '0;
                    wrap_d  = step_wraps;
                end else begin
                    count_d = count + CW'(1);
                end
            end
            default: begin
                count_d = '0;
            end
        endcase

        y_d = '0;
        if (state_d != ST_OFF) begin
            y_d[idx_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_OFF;
            idx   <= '0;
            count <= '0;
            wrap  <= 1'b0;
            y     <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            count <= count_d;
            wrap  <= wrap_d;
            y     <= y_d;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: one N=2/DIV=3 instance for decode, scan,
// load and blanking, and one N=3/DIV=1 instance for the wide single-cycle scan.
module tb_decoder_scan;

    logic       clk = 1'b0;
    logic       reset;

    logic       en, mode, load, dir;
    logic [1:0] a;
    logic [3:0] y;
    logic [1:0] idx;
    logic       wrap;
    logic [1:0] st;

    logic       en8, mode8, load8, dir8;
    logic [2:0] a8;
    logic [7:0] y8;
    logic [2:0] idx8;
    logic       wrap8;
    logic [1:0] st8;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected idx after each of the 12 edges following entry into SCAN (DIV=3, up).
    int up_idx[12]    = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    // Down scan from idx=1 with a load of 2 on the 9th edge.
    int dn_idx[12]    = '{1, 1, 0, 0, 0, 3, 3, 3, 2, 2, 2, 1};
    int dn_wrap[12]   = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

    decoder_scan #(.N(2), .DIV(3)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .load      (load),
        .dir       (dir),
        .a         (a),
        .y         (y),
        .idx       (idx),
        .wrap      (wrap),
        .dbg_state (st)
    );

    decoder_scan #(.N(3), .DIV(1)) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .en        (en8),
        .mode      (mode8),
        .load      (load8),
        .dir       (dir8),
        .a         (a8),
        .y         (y8),
        .idx       (idx8),
        .wrap      (wrap8),
        .dbg_state (st8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        en = 1'b0; mode = 1'b0; load = 1'b0; dir = 1'b0; a = '0;
        en8 = 1'b0; mode8 = 1'b0; load8 = 1'b0; dir8 = 1'b0; a8 = '0;
        tick();
        tick();
        check("reset_y", y, 4'b0000);
        check("reset_idx", idx, 2'd0);
        check("reset_state", st, 2'd0);
        reset = 1'b0;

        // Scan up to idx=1, then assert reset between edges.
        en = 1'b1; mode = 1'b1; dir = 1'b0;
        tick(); tick(); tick(); tick();
        check("prescan_idx", idx, 2'd1);
        check("prescan_y", y, 4'b0010);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_y", y, 4'b0000);
        check("async_reset_idx", idx, 2'd0);
        check("async_reset_wrap", wrap, 1'b0);
        check("async_reset_state", st, 2'd0);
        tick();
        reset = 1'b0;
        mode = 1'b0; a = 2'd2;
        tick();
        check("post_reset_decode_y", y, 4'b0100);
        check("post_reset_decode_idx", idx, 2'd2);

        // Decode sweep: one edge of latency, then stable for the interval.
        for (int k = 0; k < 4; k++) begin
            a = 2'(k);
            tick();
            check("decode_y", y, 32'(1 << k));
            check("decode_idx", idx, 32'(k));
            check("decode_state", st, 2'd1);
            for (int j = 0; j < 9; j++) tick();
            check("decode_hold_y", y, 32'(1 << k));
        end

        // Scan up from idx=0: steps at edges 3,6,9,12, wrap after edge 12.
        a = 2'd0;
        tick();
        mode = 1'b1; dir = 1'b0;
        tick();
        check("scan_entry_idx", idx, 2'd0);
        check("scan_entry_state", st, 2'd2);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("scan_up_idx", idx, 32'(up_idx[i]));
            check("scan_up_y", y, 32'(1 << up_idx[i]));
            check("scan_up_wrap", wrap, (i == 11) ? 32'd1 : 32'd0);
        end
        tick();
        check("scan_up_wrap_clear", wrap, 1'b0);

        // Scan down from idx=1; load of 2 lands on a step edge and wins.
        load = 1'b1; a = 2'd1; dir = 1'b1;
        tick();
        load = 1'b0;
        check("load_idx", idx, 2'd1);
        for (int i = 0; i < 12; i++) begin
            if (i == 8) begin
                load = 1'b1; a = 2'd2;
            end
            tick();
            load = 1'b0;
            check("scan_dn_idx", idx, 32'(dn_idx[i]));
            check("scan_dn_wrap", wrap, 32'(dn_wrap[i]));
        end

        // Blanking in SCAN at idx=2.
        load = 1'b1; a = 2'd2;
        tick();
        load = 1'b0;
        check("blank_pre_idx", idx, 2'd2);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("blank_y", y, 4'b0000);
            check("blank_idx", idx, 2'd2);
        end
        check("blank_state", st, 2'd0);
        en = 1'b1;
        tick();
        check("unblank_y", y, 4'b0100);
        tick();
        tick();
        check("unblank_hold_idx", idx, 2'd2);
        tick();
        check("unblank_step_idx", idx, 2'd1);
        check("unblank_step_y", y, 4'b0010);

        // Wide scan, one step per cycle, wrap every 8 edges.
        en8 = 1'b1; mode8 = 1'b1; dir8 = 1'b0;
        tick();
        check("wide_entry_y", y8, 8'b0000_0001);
        for (int e = 1; e <= 16; e++) begin
            tick();
            check("wide_y", y8, 32'(1 << (e % 8)));
            check("wide_wrap", wrap8, ((e % 8) == 0) ? 32'd1 : 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised N-to-2^N one-hot decoder with registered output, an enable/blanking control, and an auto-scan mode that walks the active output across all 2^N lines at a programmable rate. It generalises the fixed 2-to-4 combinational decoder into the select generator for multiplexed displays and bus-select logic. The block sits between a control register or index source and the digit/row enables it drives.

## Interface
- N, default 2: index width; output width is 2^N (N ≥ 1).
- DIV, default 4: clock cycles per scan step (DIV ≥ 1); prescaler width is clog2(DIV), minimum 1.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  1 = outputs active; 0 = blank (y all zero).
- mode  in  1  0 = decode (track a), 1 = scan (auto-advance).
- load  in  1  in scan mode, force index to a this cycle.
- dir  in  1  scan direction: 0 = up (+1), 1 = down (−1).
- a  in  N  index input.
- y  out  2^N  one-hot select, bit idx set; all zero when blanked.
- idx  out  N  current registered index.
- wrap  out  1  one-cycle pulse when a scan step wraps.

## Operation
- Three-state FSM, evaluated every rising edge: OFF, DECODE, SCAN.
- Next state from any state: en=0 → OFF; en=1 & mode=0 → DECODE; en=1 & mode=1 → SCAN.
- OFF: idx holds, prescaler cleared to 0, y = 0, wrap = 0.
- DECODE: idx <= a every cycle; prescaler held at 0; wrap = 0.
- SCAN:
  - Prescaler counts 0..DIV−1. On a cycle with count = DIV−1: count <= 0 and idx steps by ±1 modulo 2^N per dir.
  - load=1 has priority over a step: idx <= a, count <= 0, no wrap.
  - Entering SCAN from another state: count starts at 0, idx keeps its current value (no jump).
  - dir may change at any time; it is sampled at the step edge only.
- wrap: registered; set for exactly one cycle on the edge where a step moves idx from 2^N−1 to 0 (up) or from 0 to 2^N−1 (down); otherwise 0.
- y = one-hot decode of idx when state ≠ OFF, else 0. It is derived only from registered state, so it is glitch-free with respect to inputs.
- Index arithmetic is N-bit unsigned with natural wrap-around; no saturation.
- en, mode, load, dir and a are synchronous inputs, sampled on clk only.

## Timing
- Reset (async assert, synchronous release at the next edge): state = OFF, idx = 0, count = 0, y = 0, wrap = 0.
- Reset asserted mid-scan clears everything immediately, without waiting for a clock edge. After release, the block needs one edge with en=1 before y goes non-zero.
- Decode latency: a applied before edge k appears on idx/y after edge k (1 cycle).
- Scan period: in steady SCAN, idx changes every DIV cycles. With DIV=1 it changes every cycle. A full rotation takes DIV·2^N cycles.
- First step after entering SCAN or after a load occurs DIV edges later.
- Blanking: en falling before edge k gives y = 0 after edge k. en rising gives y = onehot(idx) after the next edge, with the same idx as before blanking (scan mode) or a (decode mode).
- Simultaneous load and step edge: load wins; wrap stays 0.
- A mode change on a step edge: the new state is taken and no step occurs.

## Test plan
- Reset: assert reset mid-cycle with en=1, mode=1 → y=0000, idx=0, wrap=0 immediately. Release, then en=1, mode=0, a=2 → y=0100 after one edge.
- Decode sweep (N=2): en=1, mode=0, a = 0,1,2,3 at 10-cycle intervals → y = 0001, 0010, 0100, 1000, each one edge after a changes.
- Scan up (N=2, DIV=3): en=1, mode=1, dir=0 from idx=0 → idx 1,2,3,0 at edges 3,6,9,12. wrap=1 only in the cycle after edge 12. y is always one-hot.
- Scan down with load (DIV=3): dir=1, idx=1 → steps to 0, then 3 with wrap pulse. Pulse load=1, a=2 on a step edge → idx=2, count=0, no wrap. Next step 3 edges later → idx=1.
- Blanking: in SCAN at idx=2, en=0 for 5 cycles → y=0000, idx stays 2. en=1 → y=0100 one edge later, next step DIV edges after that.
- Width check (N=3, DIV=1): scan up from 0 → y walks 00000001..10000000 one per cycle. wrap pulses every 8 cycles.
